// File: rtl/run_detect_seq_ctrl_pkg.sv
// Shared types, default sizes and width helpers for the run-of-ones detector sequencer.
package run_detect_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CW    = 4;

    // Controller states, also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a counter that must hold 0..w (hit count, run length).
    function automatic int hit_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Width of a bit index 0..w-1.
    function automatic int idx_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/run_detect_seq_ctrl_if.sv
// Producer/consumer bundle for the run detector sequencer.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
// valid must not depend on ready, and the payload is only meaningful while valid is high.
interface run_detect_seq_ctrl_if
    import run_detect_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
);
    localparam int HW = hit_w(WIDTH);
    localparam int IW = idx_w(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CW-1:0]    in_min_run;
    logic             out_valid;
    logic             out_ready;
    logic [HW-1:0]    out_hits;
    logic             out_any;
    logic [IW-1:0]    out_first_idx;
    logic             busy;

    modport master (
        output in_valid, in_data, in_min_run, out_ready,
        input  in_ready, out_valid, out_hits, out_any, out_first_idx, busy
    );

    modport slave (
        input  in_valid, in_data, in_min_run, out_ready,
        output in_ready, out_valid, out_hits, out_any, out_first_idx, busy
    );

endinterface

// File: rtl/run_detect_seq_ctrl_run_len_detector.sv
// Serial run-length detector: tracks the current run of ones and flags a hit when
// the run including the present bit reaches the threshold.
module run_len_detector
    import run_detect_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bit_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [CW-1:0] min_run_i,
    output logic          hit_o
);
    localparam int HW = hit_w(WIDTH);
    localparam logic [HW-1:0] RUN_MAX = HW'(WIDTH);

    logic [HW-1:0] run_q;
    logic [HW-1:0] run_d;
    logic [HW-1:0] run_inc;
    logic [HW-1:0] run_next;

    // Next run length, saturating at WIDTH; hit is combinational from run_q and the bit.
    always_comb begin
        run_inc  = (run_q == RUN_MAX) ? run_q : run_q + HW'(1);
        run_next = bit_i ? run_inc : '0;
        hit_o    = en_i & bit_i & (32'(run_next) >= 32'(min_run_i));
        run_d    = run_q;
        if (clr_i) begin
            run_d = '0;
        end else if (en_i) begin
            run_d = run_next;
        end
    end

    // Run counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/run_detect_seq_ctrl.sv
// Sequencer: accepts a word, shifts it MSB-first through the run detector one bit per
// clock, accumulates hit count / first hit index and presents the result until taken.
module run_detect_seq_ctrl
    import run_detect_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic                    clk,
    input  logic                    rst,
    run_detect_seq_ctrl_if.slave    bus,
    output state_t                  dbg_state_o
);
    localparam int HW = hit_w(WIDTH);
    localparam int IW = idx_w(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    min_q, min_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [HW-1:0]    hits_q, hits_d;
    logic [IW-1:0]    first_q, first_d;
    logic             any_q, any_d;
    logic             det_en, det_clr, det_hit;

    run_len_detector #(.WIDTH(WIDTH), .CW(CW)) u_det (
        .clk       (clk),
        .rst       (rst),
        .bit_i     (word_q[idx_q]),
        .en_i      (det_en),
        .clr_i     (det_clr),
        .min_run_i (min_q),
        .hit_o     (det_hit)
    );

    // Next-state and datapath updates; every output is derived from registers only.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        min_d   = min_q;
        idx_d   = idx_q;
        hits_d  = hits_q;
        first_d = first_q;
        any_d   = any_q;
        det_en  = 1'b0;
        det_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    // A threshold of 0 behaves like 1: any single one is a hit.
                    min_d   = (bus.in_min_run == '0) ? CW'(1) : bus.in_min_run;
                    idx_d   = IW'(WIDTH - 1);
                    hits_d  = '0;
                    first_d = '0;
                    any_d   = 1'b0;
                    det_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                det_en = 1'b1;
                if (det_hit) begin
                    hits_d = hits_q + HW'(1);
                    if (!any_q) begin
                        first_d = idx_q;
                        any_d   = 1'b1;
                    end
                end
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            min_q   <= '0;
            idx_q   <= '0;
            hits_q  <= '0;
            first_q <= '0;
            any_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
            hits_q  <= hits_d;
            first_q <= first_d;
            any_q   <= any_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.out_hits      = hits_q;
    assign bus.out_any       = any_q;
    assign bus.out_first_idx = first_q;
    assign dbg_state_o       = state_q;

endmodule
